// File: rtl/ex_stage_ctrl.sv
// rtl/ex_stage_ctrl.sv - execute stage controller: EX/WB registers, branch squash and redirect, counters
module ex_stage_ctrl #(
  parameter int BITS  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [2:0]       id_op,
  input  logic [BITS-1:0]  id_s1,
  input  logic [BITS-1:0]  id_s2,
  input  logic [BITS-1:0]  id_pc,
  input  logic [RD_W-1:0]  id_rd,
  output logic [2:0]       ex_op,
  output logic [BITS-1:0]  ex_s1,
  output logic [BITS-1:0]  ex_s2,
  output logic [BITS-1:0]  ex_pc,
  input  logic [BITS-1:0]  ex_alu_result,
  input  logic [BITS:0]    ex_bjbus,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [BITS-1:0]  wb_result,
  output logic [RD_W-1:0]  wb_rd,
  output logic             flush,
  output logic [BITS-1:0]  redirect_pc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic            exVld;
  logic [RD_W-1:0] exRd;
  logic            exReady;
  logic            exFire;
  logic            idFire;
  logic            takenFire;
  logic            wbDrain;

  // EX may advance whenever the WB slot is empty or being drained this cycle.
  assign exReady   = !wb_valid || wb_ready;
  assign exFire    = exVld && exReady;
  assign id_ready  = (!exVld || exReady) && !flush;
  assign idFire    = id_valid && id_ready;
  // The taken bit only means anything when a real instruction is leaving EX.
  assign takenFire = exFire && ex_bjbus[BITS];
  assign wbDrain   = wb_valid && wb_ready;

  // EX register: a taken branch empties EX and discards the wrong-path load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exVld <= 1'b0;
      ex_op <= '0;
      ex_s1 <= '0;
      ex_s2 <= '0;
      ex_pc <= '0;
      exRd  <= '0;
    end else if (takenFire) begin
      exVld <= 1'b0;
    end else if (idFire) begin
      exVld <= 1'b1;
      ex_op <= id_op;
      ex_s1 <= id_s1;
      ex_s2 <= id_s2;
      ex_pc <= id_pc;
      exRd  <= id_rd;
    end else if (exFire) begin
      exVld <= 1'b0;
    end
  end

  // WB register: captures the combinational execute result as the instruction leaves EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_result <= '0;
      wb_rd     <= '0;
    end else if (exFire) begin
      wb_valid  <= 1'b1;
      wb_result <= ex_alu_result;
      wb_rd     <= exRd;
    end else if (wb_ready) begin
      wb_valid  <= 1'b0;
    end
  end

  // Redirect: one-cycle flush pulse carrying the branch target sampled at the branch edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= takenFire;
      if (takenFire) begin
        redirect_pc <= ex_bjbus[BITS-1:0];
      end
    end
  end

  // Performance counters, free-running and wrapping at their natural width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (wbDrain) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (takenFire) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb/tb_ex_stage_ctrl.sv - scoreboard bench for ex_stage_ctrl
module tb_ex_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_op;
  logic [31:0] id_s1;
  logic [31:0] id_s2;
  logic [31:0] id_pc;
  logic [4:0]  id_rd;
  logic        wb_ready;

  logic        id_ready;
  logic [2:0]  ex_op;
  logic [31:0] ex_s1, ex_s2, ex_pc;
  logic [31:0] ex_alu_result;
  logic [32:0] ex_bjbus;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] retire_cnt, taken_cnt;

  logic        id_ready4;
  logic [2:0]  ex_op4;
  logic [31:0] ex_s14, ex_s24, ex_pc4;
  logic [31:0] ex_alu_result4;
  logic [32:0] ex_bjbus4;
  logic        wb_valid4;
  logic [31:0] wb_result4;
  logic [4:0]  wb_rd4;
  logic        flush4;
  logic [31:0] redirect_pc4;
  logic [3:0]  retire_cnt4, taken_cnt4;

  int          nChecks = 0;
  int          nBad = 0;
  int          flushCount = 0;
  bit          dropNext = 0;
  bit          accepted = 0;
  logic [36:0] sb[$];

  // Behavioural stand-in for the combinational execute datapath.
  function automatic logic [31:0] aluModel(logic [2:0] op, logic [31:0] s1, logic [31:0] s2, logic [31:0] pc);
    case (op)
      3'd0: return s1 + s2;
      3'd1: return s1 - s2;
      3'd2: return s1 & s2;
      3'd3: return s1 | s2;
      3'd4: return s1 ^ s2;
      3'd5: return s1 << s2[4:0];
      3'd6: return ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
      default: return pc + 32'd4;
    endcase
  endfunction

  // op 7 with s1[31] set is a taken jump to s2; its WB value is the link pc+4.
  assign ex_alu_result  = aluModel(ex_op, ex_s1, ex_s2, ex_pc);
  assign ex_bjbus       = {(ex_op == 3'd7) && ex_s1[31], ex_s2};
  assign ex_alu_result4 = aluModel(ex_op4, ex_s14, ex_s24, ex_pc4);
  assign ex_bjbus4      = {(ex_op4 == 3'd7) && ex_s14[31], ex_s24};

  ex_stage_ctrl #(.BITS(32), .RD_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_s1(id_s1), .id_s2(id_s2), .id_pc(id_pc), .id_rd(id_rd),
    .ex_op(ex_op), .ex_s1(ex_s1), .ex_s2(ex_s2), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_bjbus(ex_bjbus),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_rd(wb_rd),
    .flush(flush), .redirect_pc(redirect_pc), .retire_cnt(retire_cnt), .taken_cnt(taken_cnt)
  );

  ex_stage_ctrl #(.BITS(32), .RD_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready4),
    .id_op(id_op), .id_s1(id_s1), .id_s2(id_s2), .id_pc(id_pc), .id_rd(id_rd),
    .ex_op(ex_op4), .ex_s1(ex_s14), .ex_s2(ex_s24), .ex_pc(ex_pc4),
    .ex_alu_result(ex_alu_result4), .ex_bjbus(ex_bjbus4),
    .wb_valid(wb_valid4), .wb_ready(wb_ready), .wb_result(wb_result4), .wb_rd(wb_rd4),
    .flush(flush4), .redirect_pc(redirect_pc4), .retire_cnt(retire_cnt4), .taken_cnt(taken_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: score WB output and ID acceptance at the negedge, return just after the posedge.
  task automatic cyc();
    logic [36:0] e;
    @(negedge clk);
    if (wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        checkVal("sb_extra", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        checkVal("wb_result", 64'(wb_result), 64'(e[36:5]));
        checkVal("wb_rd", 64'(wb_rd), 64'(e[4:0]));
      end
    end
    if (flush) flushCount++;
    accepted = id_valid && id_ready;
    if (accepted) begin
      // The instruction accepted on a taken branch's edge is wrong-path and must vanish.
      if (dropNext) dropNext = 1'b0;
      else begin
        sb.push_back({aluModel(id_op, id_s1, id_s2, id_pc), id_rd});
        if (id_op == 3'd7 && id_s1[31]) dropNext = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] pc, input logic [4:0] rd);
    id_valid = 1'b1;
    id_op = op;
    id_s1 = s1;
    id_s2 = s2;
    id_pc = pc;
    id_rd = rd;
  endtask

  task automatic drain();
    id_valid = 1'b0;
    wb_ready = 1'b1;
    for (int k = 0; k < 30 && sb.size() != 0; k++) cyc();
    cyc();
    checkVal("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic midReset();
    #2;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic releaseReset();
    sb.delete();
    dropNext = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0;
    id_op = '0; id_s1 = '0; id_s2 = '0; id_pc = '0; id_rd = '0;
    wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkVal("rst_flush", 64'(flush), 64'd0);
    checkVal("rst_ex_s1", 64'(ex_s1), 64'd0);
    checkVal("rst_ex_pc", 64'(ex_pc), 64'd0);
    checkVal("rst_wb_result", 64'(wb_result), 64'd0);
    checkVal("rst_redirect", 64'(redirect_pc), 64'd0);
    checkVal("rst_retire", 64'(retire_cnt), 64'd0);
    checkVal("rst_taken", 64'(taken_cnt), 64'd0);
    releaseReset();
    checkVal("rst_id_ready", 64'(id_ready), 64'd1);

    // Full-rate stream.
    for (int i = 0; i < 8; i++) begin
      offer(3'(i), 32'(2 + i), 32'(3 + i), 32'(4 * i), 5'(i + 1));
      checkVal("s_id_ready", 64'(id_ready), 64'd1);
      checkVal("s_wb_valid", 64'(wb_valid), 64'(i >= 2));
      cyc();
    end
    drain();
    checkVal("s_retire", 64'(retire_cnt), 64'd8);
    checkVal("s_taken", 64'(taken_cnt), 64'd0);

    // Backpressure with two instructions queued.
    wb_ready = 1'b0;
    offer(3'd0, 32'd100, 32'd5, 32'h200, 5'd9);
    cyc();
    offer(3'd1, 32'd50, 32'd8, 32'h204, 5'd10);
    cyc();
    offer(3'd4, 32'hF0, 32'h0F, 32'h208, 5'd11);
    for (int k = 0; k < 3; k++) begin
      checkVal("bp_id_ready", 64'(id_ready), 64'd0);
      checkVal("bp_wb_valid", 64'(wb_valid), 64'd1);
      checkVal("bp_wb_result", 64'(wb_result), 64'd105);
      checkVal("bp_ex_s1", 64'(ex_s1), 64'd50);
      cyc();
    end
    wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (accepted) break;
    end
    checkVal("bp_accept", 64'(accepted), 64'd1);
    drain();
    checkVal("bp_retire", 64'(retire_cnt), 64'd11);

    // Taken branch at full rate.
    flushCount = 0;
    offer(3'd7, 32'h8000_0000, 32'h40, 32'h100, 5'd1);
    cyc();
    offer(3'd0, 32'd1, 32'd1, 32'h104, 5'd2);
    checkVal("br_flush_pre", 64'(flush), 64'd0);
    checkVal("br_ex_pc", 64'(ex_pc), 64'h100);
    cyc();
    offer(3'd0, 32'd2, 32'd2, 32'h108, 5'd3);
    checkVal("br_flush", 64'(flush), 64'd1);
    checkVal("br_redirect", 64'(redirect_pc), 64'h40);
    checkVal("br_id_ready", 64'(id_ready), 64'd0);
    cyc();
    offer(3'd2, 32'hFF, 32'h0F, 32'h40, 5'd4);
    checkVal("br_flush_post", 64'(flush), 64'd0);
    cyc();
    drain();
    checkVal("br_taken", 64'(taken_cnt), 64'd1);
    checkVal("br_retire", 64'(retire_cnt), 64'd13);
    checkVal("br_flush_count", 64'(flushCount), 64'd1);

    // Taken branch held in EX behind a stalled WB.
    wb_ready = 1'b0;
    offer(3'd3, 32'hA0, 32'h05, 32'h300, 5'd5);
    cyc();
    offer(3'd7, 32'h8000_0001, 32'h80, 32'h304, 5'd6);
    cyc();
    offer(3'd0, 32'd9, 32'd9, 32'h308, 5'd7);
    for (int k = 0; k < 3; k++) begin
      checkVal("bbp_flush", 64'(flush), 64'd0);
      checkVal("bbp_id_ready", 64'(id_ready), 64'd0);
      cyc();
    end
    wb_ready = 1'b1;
    checkVal("bbp_flush_rel", 64'(flush), 64'd0);
    cyc();
    offer(3'd0, 32'd1, 32'd2, 32'h30C, 5'd8);
    checkVal("bbp_flush_on", 64'(flush), 64'd1);
    checkVal("bbp_redirect", 64'(redirect_pc), 64'h80);
    cyc();
    offer(3'd1, 32'h90, 32'h10, 32'h80, 5'd9);
    checkVal("bbp_flush_off", 64'(flush), 64'd0);
    cyc();
    drain();
    checkVal("bbp_taken", 64'(taken_cnt), 64'd2);
    checkVal("bbp_retire", 64'(retire_cnt), 64'd16);
    checkVal("bbp_flush_count", 64'(flushCount), 64'd2);

    // Asynchronous reset with both EX and WB occupied.
    wb_ready = 1'b0;
    offer(3'd0, 32'd7, 32'd7, 32'h500, 5'd1);
    cyc();
    offer(3'd0, 32'd8, 32'd8, 32'h504, 5'd2);
    cyc();
    id_valid = 1'b0;
    checkVal("ar_pre_wb_valid", 64'(wb_valid), 64'd1);
    checkVal("ar_pre_id_ready", 64'(id_ready), 64'd0);
    midReset();
    checkVal("ar_wb_valid", 64'(wb_valid), 64'd0);
    checkVal("ar_flush", 64'(flush), 64'd0);
    checkVal("ar_retire", 64'(retire_cnt), 64'd0);
    checkVal("ar_taken", 64'(taken_cnt), 64'd0);
    checkVal("ar_id_ready", 64'(id_ready), 64'd1);
    releaseReset();

    // Asynchronous reset during a flush pulse.
    wb_ready = 1'b1;
    offer(3'd7, 32'h8000_0000, 32'h44, 32'h400, 5'd1);
    cyc();
    offer(3'd0, 32'd3, 32'd3, 32'h404, 5'd2);
    cyc();
    id_valid = 1'b0;
    checkVal("arf_pre_flush", 64'(flush), 64'd1);
    midReset();
    checkVal("arf_flush", 64'(flush), 64'd0);
    checkVal("arf_wb_valid", 64'(wb_valid), 64'd0);
    checkVal("arf_redirect", 64'(redirect_pc), 64'd0);
    releaseReset();

    // Counter wrap on the 4-bit instance.
    wb_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      offer(3'(i % 8), 32'(i * 3), 32'(i + 1), 32'(32'h1000 + 4 * i), 5'(i));
      cyc();
    end
    drain();
    checkVal("wrap_retire4", 64'(retire_cnt4), 64'd1);
    checkVal("wrap_retire", 64'(retire_cnt), 64'd17);
    checkVal("wrap_taken4", 64'(taken_cnt4), 64'd0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
